// File: rtl/fpu_seq.sv
// fpu_seq: multi-cycle IEEE-754-style ADD/SUB/MUL/DIV core with round-to-nearest-even and exception flags.
// Latency: 4 edges for ADD/SUB/MUL, MAN_W+7 edges for DIV (accepting edge counted as the first).
// Backpressure: one operation in flight; in_ready only in IDLE, result/flags held in HOLD until out_ready.
module fpu_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             opcode,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [4:0]             flags
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int EW  = EXP_W + 2;          // signed working exponent
   localparam int MW  = MAN_W + 5;          // {carry, int, frac, guard, round, sticky}
   localparam int SH  = MAN_W + 4;          // aligned small operand incl. G/R/S slots
   localparam int CW  = $clog2(MAN_W + 4);  // divide iteration counter
   localparam int LW  = $clog2(MW + 1);     // leading-zero count
   localparam int XW  = EW + LW;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ALIGN  = 3'd1;
   localparam logic [2:0] S_DIVIDE = 3'd2;
   localparam logic [2:0] S_NORM   = 3'd3;
   localparam logic [2:0] S_ROUND  = 3'd4;
   localparam logic [2:0] S_HOLD   = 3'd5;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b10;
   localparam logic [1:0] OP_MUL = 2'b11;

   localparam logic [EXP_W-1:0]    EXP_ONES = {EXP_W{1'b1}};
   localparam logic [MAN_W-1:0]    FRAC_Z   = {MAN_W{1'b0}};
   localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic signed [EW-1:0] BIAS_S  = EW'((1 << (EXP_W-1)) - 1);
   localparam logic signed [EW-1:0] EMAX_S  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] ONE_S   = EW'(1);
   localparam logic signed [EW-1:0] ZERO_S  = EW'(0);

   logic [2:0]              state_q, state_d;
   logic [1:0]              op_q, op_d;
   logic [W-1:0]            a_q, a_d, b_q, b_d;
   logic                    sign_q, sign_d;
   logic signed [EW-1:0]    exp_q, exp_d;
   logic [MW-1:0]           man_q, man_d;
   logic                    spc_q, spc_d;
   logic [W-1:0]            spc_res_q, spc_res_d;
   logic [4:0]              spc_flg_q, spc_flg_d;
   logic [MAN_W+1:0]        rem_q, rem_d;
   logic [MAN_W+2:0]        quo_q, quo_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [W-1:0]            res_q, res_d;
   logic [4:0]              flg_q, flg_d;

   // Operand field decode and classification (denormals behave as zero).
   logic                    sa, sb, sbe;
   logic [EXP_W-1:0]        ea, eb;
   logic [MAN_W-1:0]        fa, fb;
   logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [MAN_W:0]          ma, mb;

   assign sa     = a_q[W-1];
   assign sb     = b_q[W-1];
   assign sbe    = sb ^ (op_q == OP_SUB);
   assign ea     = a_q[W-2:MAN_W];
   assign eb     = b_q[W-2:MAN_W];
   assign fa     = a_q[MAN_W-1:0];
   assign fb     = b_q[MAN_W-1:0];
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == EXP_ONES) && (fa == '0);
   assign b_inf  = (eb == EXP_ONES) && (fb == '0);
   assign a_nan  = (ea == EXP_ONES) && (fa != '0);
   assign b_nan  = (eb == EXP_ONES) && (fb != '0);
   assign ma     = {1'b1, fa};
   assign mb     = {1'b1, fb};

   // ADD/SUB alignment: larger magnitude first, smaller shifted right with saturating sticky.
   logic                    a_ge_b, eff_sub, sat;
   logic [EXP_W-1:0]        el, es, ediff;
   logic [MAN_W:0]          ml, ms;
   logic [31:0]             shamt;
   logic [2*SH-1:0]         shv;
   logic [SH-1:0]           al;
   logic [MW-1:0]           lx, sx, sum;

   always_comb begin
      a_ge_b  = ({ea, fa} >= {eb, fb});
      eff_sub = sa ^ sbe;
      el      = a_ge_b ? ea : eb;
      es      = a_ge_b ? eb : ea;
      ml      = a_ge_b ? ma : mb;
      ms      = a_ge_b ? mb : ma;
      ediff   = el - es;
      sat     = (32'(ediff) > 32'(MAN_W + 3));
      shamt   = sat ? 32'(MAN_W + 3) : 32'(ediff);
      shv     = {ms, 3'b000, {SH{1'b0}}} >> shamt;
      al      = shv[2*SH-1:SH];
      lx      = {1'b0, ml, 3'b000};
      sx      = {1'b0, al[SH-1:1], al[0] | (|shv[SH-1:0])};
      sum     = eff_sub ? (lx - sx) : (lx + sx);
   end

   // Significand product mapped onto the working format; low bits fold into sticky.
   logic [2*MAN_W+1:0]      prod;
   logic [2*MAN_W+4:0]      pe;
   logic [MW-1:0]           mul_man;

   always_comb begin
      prod    = {{(MAN_W+1){1'b0}}, ma} * {{(MAN_W+1){1'b0}}, mb};
      pe      = {prod, 3'b000};
      mul_man = {pe[2*MAN_W+4:MAN_W+1], |pe[MAN_W:0]};
   end

   // One restoring-division step: compare, conditionally subtract, shift.
   logic                    rem_ge;
   logic [MAN_W+1:0]        diff, rem_nx;
   logic [MAN_W+2:0]        quo_nx;

   always_comb begin
      rem_ge = (rem_q >= {1'b0, mb});
      diff   = rem_ge ? (rem_q - {1'b0, mb}) : rem_q;
      rem_nx = {diff[MAN_W:0], 1'b0};
      quo_nx = {quo_q[MAN_W+1:0], rem_ge};
   end

   // Special-operand resolution; the chosen value rides through the pipeline unchanged.
   logic                    sp_hit;
   logic [W-1:0]            sp_val;
   logic [4:0]              sp_flg;

   always_comb begin
      sp_hit = 1'b0;
      sp_val = '0;
      sp_flg = '0;
      if (a_nan || b_nan) begin
         sp_hit = 1'b1;
         sp_val = QNAN;
      end else begin
         case (op_q)
            OP_MUL: begin
               if ((a_zero && b_inf) || (a_inf && b_zero)) begin
                  sp_hit = 1'b1; sp_val = QNAN; sp_flg = 5'b10000;
               end else if (a_inf || b_inf) begin
                  sp_hit = 1'b1; sp_val = {sa ^ sb, EXP_ONES, FRAC_Z};
               end else if (a_zero || b_zero) begin
                  sp_hit = 1'b1; sp_val = {sa ^ sb, {(W-1){1'b0}}};
               end
            end
            OP_DIV: begin
               if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                  sp_hit = 1'b1; sp_val = QNAN; sp_flg = 5'b10000;
               end else if (a_inf) begin
                  sp_hit = 1'b1; sp_val = {sa ^ sb, EXP_ONES, FRAC_Z};
               end else if (b_zero) begin
                  sp_hit = 1'b1; sp_val = {sa ^ sb, EXP_ONES, FRAC_Z}; sp_flg = 5'b01000;
               end else if (b_inf || a_zero) begin
                  sp_hit = 1'b1; sp_val = {sa ^ sb, {(W-1){1'b0}}};
               end
            end
            default: begin
               if (a_inf && b_inf) begin
                  sp_hit = 1'b1;
                  if (sa != sbe) begin
                     sp_val = QNAN; sp_flg = 5'b10000;
                  end else begin
                     sp_val = {sa, EXP_ONES, FRAC_Z};
                  end
               end else if (a_inf) begin
                  sp_hit = 1'b1; sp_val = {sa, EXP_ONES, FRAC_Z};
               end else if (b_inf) begin
                  sp_hit = 1'b1; sp_val = {sbe, EXP_ONES, FRAC_Z};
               end else if (a_zero && b_zero) begin
                  sp_hit = 1'b1; sp_val = {sa & sbe, {(W-1){1'b0}}};
               end else if (a_zero) begin
                  sp_hit = 1'b1; sp_val = {sbe, b_q[W-2:0]};
               end else if (b_zero) begin
                  sp_hit = 1'b1; sp_val = a_q;
               end
            end
         endcase
      end
   end

   // Leading-zero count below the carry bit, used to undo cancellation.
   logic [LW-1:0]           lz;
   logic                    found;
   logic signed [XW-1:0]    exp_lz;

   always_comb begin
      lz    = '0;
      found = 1'b0;
      for (int i = MW-2; i >= 0; i--) begin
         if (!found) begin
            if (man_q[i]) found = 1'b1;
            else          lz    = lz + 1'b1;
         end
      end
      exp_lz = {{LW{exp_q[EW-1]}}, exp_q} - {{EW{1'b0}}, lz};
   end

   // Round to nearest even, then range-check the exponent.
   logic                    g_b, r_b, s_b, rup, inx;
   logic [MAN_W+1:0]        sig;
   logic signed [EW-1:0]    exp_r;
   logic [MAN_W-1:0]        frac_r;
   logic [W-1:0]            rnd_val;
   logic [4:0]              rnd_flg;

   always_comb begin
      g_b    = man_q[2];
      r_b    = man_q[1];
      s_b    = man_q[0];
      inx    = g_b | r_b | s_b;
      rup    = g_b & (r_b | s_b | man_q[3]);
      sig    = {1'b0, man_q[MW-2:3]} + {{(MAN_W+1){1'b0}}, rup};
      exp_r  = exp_q + $signed({{(EW-1){1'b0}}, sig[MAN_W+1]});
      frac_r = sig[MAN_W+1] ? sig[MAN_W:1] : sig[MAN_W-1:0];
      if (spc_q) begin
         rnd_val = spc_res_q;
         rnd_flg = spc_flg_q;
      end else if (man_q == '0) begin
         rnd_val = '0;
         rnd_flg = '0;
      end else if (exp_r >= EMAX_S) begin
         rnd_val = {sign_q, EXP_ONES, FRAC_Z};
         rnd_flg = 5'b00101;
      end else if (exp_r <= ZERO_S) begin
         rnd_val = {sign_q, {(W-1){1'b0}}};
         rnd_flg = 5'b00011;
      end else begin
         rnd_val = {sign_q, exp_r[EXP_W-1:0], frac_r};
         rnd_flg = {4'b0000, inx};
      end
   end

   // Sequencer: next-state for the FSM and all datapath registers.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      man_d     = man_q;
      spc_d     = spc_q;
      spc_res_d = spc_res_q;
      spc_flg_d = spc_flg_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      flg_d     = flg_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d    = opcode;
               a_d     = a;
               b_d     = b;
               state_d = S_ALIGN;
            end
         end
         S_ALIGN: begin
            spc_d     = sp_hit;
            spc_res_d = sp_val;
            spc_flg_d = sp_flg;
            case (op_q)
               OP_MUL: begin
                  sign_d  = sa ^ sb;
                  exp_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
                  man_d   = mul_man;
                  state_d = S_NORM;
               end
               OP_DIV: begin
                  sign_d  = sa ^ sb;
                  exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;
                  rem_d   = {1'b0, ma};
                  quo_d   = '0;
                  cnt_d   = '0;
                  state_d = S_DIVIDE;
               end
               default: begin
                  sign_d  = a_ge_b ? sa : sbe;
                  exp_d   = $signed({2'b00, el});
                  man_d   = sum;
                  state_d = S_NORM;
               end
            endcase
         end
         S_DIVIDE: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(MAN_W + 2)) begin
               man_d   = {1'b0, quo_nx, |diff};
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            if (man_q[MW-1]) begin
               man_d = {1'b0, man_q[MW-1:2], man_q[1] | man_q[0]};
               exp_d = exp_q + ONE_S;
            end else if (!man_q[MW-2] && (man_q != '0)) begin
               man_d = man_q << lz;
               exp_d = (exp_lz[XW-1] || (exp_lz == '0)) ? ZERO_S : exp_lz[EW-1:0];
            end
            state_d = S_ROUND;
         end
         S_ROUND: begin
            res_d   = rnd_val;
            flg_d   = rnd_flg;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous active-low reset; reset discards any in-flight op.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         man_q     <= '0;
         spc_q     <= 1'b0;
         spc_res_q <= '0;
         spc_flg_q <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         res_q     <= '0;
         flg_q     <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         man_q     <= man_d;
         spc_q     <= spc_d;
         spc_res_q <= spc_res_d;
         spc_flg_q <= spc_flg_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         cnt_q     <= cnt_d;
         res_q     <= res_d;
         flg_q     <= flg_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_HOLD);
   assign result    = res_q;
   assign flags     = flg_q;

endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: directed vectors against a single-precision and a half-precision fpu_seq.
// Latency: each op is timed edge by edge from the accepting edge.
// Backpressure: exercises held out_ready, output handshake and reset during DIVIDE.
module tb_fpu_seq;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b10;
   localparam logic [1:0] OP_MUL = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iv0, ir0, ov0, or0, iv1, ir1, ov1, or1;
   logic [1:0]  op0, op1;
   logic [31:0] a0, b0, res0;
   logic [15:0] a1, b1, res1;
   logic [4:0]  fl0, fl1;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   always #5 clk = ~clk;

   fpu_seq #(.EXP_W(8), .MAN_W(23)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .opcode(op0),
      .a(a0), .b(b0), .out_valid(ov0), .out_ready(or0), .result(res0), .flags(fl0)
   );

   fpu_seq #(.EXP_W(5), .MAN_W(10)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .opcode(op1),
      .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1), .result(res1), .flags(fl1)
   );

   function automatic logic [31:0] g_res(input int sel);
      return (sel == 0) ? res0 : {16'h0000, res1};
   endfunction
   function automatic logic [31:0] g_flg(input int sel);
      return (sel == 0) ? {27'd0, fl0} : {27'd0, fl1};
   endfunction
   function automatic logic [31:0] g_ir(input int sel);
      return (sel == 0) ? {31'd0, ir0} : {31'd0, ir1};
   endfunction
   function automatic logic [31:0] g_ov(input int sel);
      return (sel == 0) ? {31'd0, ov0} : {31'd0, ov1};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input int sel, input logic [1:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input string tag);
      @(negedge clk);
      check({tag, " in_ready"}, g_ir(sel), 32'd1);
      if (sel == 0) begin
         op0 = op; a0 = av; b0 = bv; iv0 = 1'b1;
      end else begin
         op1 = op; a1 = av[15:0]; b1 = bv[15:0]; iv1 = 1'b1;
      end
      @(posedge clk);
      #1;
      iv0 = 1'b0;
      iv1 = 1'b0;
   endtask

   task automatic wait_out(input int sel, input int lat, input string tag);
      int n = 1;
      while ((g_ov(sel) != 32'd1) && (n < 200)) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, " latency"}, n, lat);
   endtask

   task automatic take_out(input int sel, input string tag);
      @(negedge clk);
      if (sel == 0) or0 = 1'b1; else or1 = 1'b1;
      @(posedge clk);
      #1;
      or0 = 1'b0;
      or1 = 1'b0;
      check({tag, " out_valid drop"}, g_ov(sel), 32'd0);
   endtask

   task automatic run_op(input int sel, input logic [1:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] er, input logic [4:0] ef,
                         input int lat, input string tag);
      issue(sel, op, av, bv, tag);
      wait_out(sel, lat, tag);
      @(negedge clk);
      check({tag, " result"}, g_res(sel), er);
      check({tag, " flags"}, g_flg(sel), {27'd0, ef});
      take_out(sel, tag);
   endtask

   initial begin
      rst_n = 1'b0;
      iv0 = 1'b0; or0 = 1'b0; op0 = 2'b00; a0 = '0; b0 = '0;
      iv1 = 1'b0; or1 = 1'b0; op1 = 2'b00; a1 = '0; b1 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready",  g_ir(0),  32'd1);
      check("reset out_valid", g_ov(0),  32'd0);
      check("reset result",    g_res(0), 32'd0);
      check("reset flags",     g_flg(0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(0, OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 5'b00000, 4,  "add 1+2");
      run_op(0, OP_SUB, 32'h40400000, 32'h40400000, 32'h00000000, 5'b00000, 4,  "sub 3-3");
      run_op(0, OP_SUB, 32'h3FC00000, 32'h3F800000, 32'h3F000000, 5'b00000, 4,  "sub cancel");
      run_op(0, OP_ADD, 32'h00000000, 32'hC0000000, 32'hC0000000, 5'b00000, 4,  "add zero");
      run_op(0, OP_ADD, 32'h3F800000, 32'h33800000, 32'h3F800000, 5'b00001, 4,  "tie even");
      run_op(0, OP_ADD, 32'h3F800001, 32'h33800000, 32'h3F800002, 5'b00001, 4,  "tie odd");
      run_op(0, OP_MUL, 32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, 4,  "mul 1.5x2");
      run_op(0, OP_MUL, 32'h7F000000, 32'h40000000, 32'h7F800000, 5'b00101, 4,  "mul ovf");
      run_op(0, OP_MUL, 32'h00800000, 32'h3F000000, 32'h00000000, 5'b00011, 4,  "mul unf");
      run_op(0, OP_DIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 30, "div 1/3");
      run_op(0, OP_DIV, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 30, "div 6/2");
      run_op(0, OP_DIV, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 30, "div by 0");
      run_op(0, OP_ADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 4,  "inf-inf");
      run_op(0, OP_MUL, 32'h00000000, 32'h7F800000, 32'h7FC00000, 5'b10000, 4,  "0xinf");

      // Result held while the consumer stalls.
      issue(0, OP_MUL, 32'h3FC00000, 32'h40000000, "hold");
      wait_out(0, 4, "hold");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold result",    g_res(0), 32'h40400000);
         check("hold in_ready",  g_ir(0),  32'd0);
         check("hold out_valid", g_ov(0),  32'd1);
      end
      take_out(0, "hold");

      // Reset arriving in the twelfth DIVIDE cycle.
      issue(0, OP_DIV, 32'h3F800000, 32'h40400000, "rst div");
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("mid div in_ready",  g_ir(0), 32'd0);
      check("mid div out_valid", g_ov(0), 32'd0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst div out_valid", g_ov(0),  32'd0);
      check("rst div in_ready",  g_ir(0),  32'd1);
      check("rst div result",    g_res(0), 32'd0);
      check("rst div flags",     g_flg(0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(0, OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 5'b00000, 4, "add after rst");

      // Half-precision instance.
      run_op(1, OP_ADD, 32'h00003C00, 32'h00004000, 32'h00004200, 5'b00000, 4,  "h add 1+2");
      run_op(1, OP_DIV, 32'h00003C00, 32'h00004200, 32'h00003555, 5'b00001, 17, "h div 1/3");
      run_op(1, OP_DIV, 32'h00003C00, 32'h00000000, 32'h00007C00, 5'b01000, 17, "h div by 0");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
